// File: rtl/tb_axi_stream_sink.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_axi_stream_sink
//   Bench-side AXI-stream consumer. Drives tready from a Galois LFSR to apply
//   programmable pseudo-random back-pressure, reassembles tlast-delimited
//   packets, and reports per-packet kept-byte count and gzip CRC-32. Sticky
//   flags report tkeep shapes that are not contiguous from lane 0, and non-last
//   beats that do not carry a full set of lanes.
//
//   Optional build macro: TB_AXI_STREAM_SINK_DISPLAY_EN
//     When defined, every completed packet is logged, and the first assertion
//     of each error flag prints an error line. Port behaviour is unchanged.
// -----------------------------------------------------------------------------
module tb_axi_stream_sink #(
  parameter int          DWIDTH     = 32,
  parameter int          READY_PROB = 256,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                tready,
  input  logic                tvalid,
  input  logic [DWIDTH-1:0]   tdata,
  input  logic                tlast,
  input  logic [DWIDTH/8-1:0] tkeep,
  output logic                pkt_done,
  output logic [31:0]         pkt_bytes,
  output logic [31:0]         pkt_crc,
  output logic [31:0]         pkt_cnt,
  output logic                busy,
  output logic                err_keep_gap,
  output logic                err_keep_partial
);

  localparam int          LANES        = DWIDTH / 8;
  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] LFSR_INIT    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam bit          ALWAYS_READY = (READY_PROB >= 256);
  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Reflected CRC-32 update for one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc,
                                           input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Number of kept lanes in a beat.
  function automatic logic [31:0] popcount(input logic [LANES-1:0] keep);
    logic [31:0] cnt;
    cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + {31'h0, keep[i]};
    end
    return cnt;
  endfunction

  // True when keep has the form 0..01..1 (including all-zero and all-one).
  // Adding one to such a value clears every set bit, so the AND is zero.
  function automatic logic keep_contiguous(input logic [LANES-1:0] keep);
    logic [LANES-1:0] kp1;
    kp1 = keep + LANES'(1);
    return ((keep & kp1) == '0);
  endfunction

  // Running CRC across the kept lanes of one beat; holes are skipped.
  function automatic logic [31:0] crc_beat(input logic [31:0]       crc,
                                           input logic [DWIDTH-1:0] data,
                                           input logic [LANES-1:0]  keep);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < LANES; i++) begin
      if (keep[i]) begin
        c = crc_byte(c, data[8*i +: 8]);
      end
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q,      state_d;
  logic [15:0] lfsr_q,       lfsr_d;
  logic        tready_q,     tready_d;
  logic [31:0] acc_bytes_q,  acc_bytes_d;
  logic [31:0] crc_q,        crc_d;
  logic        pkt_done_q,   pkt_done_d;
  logic [31:0] pkt_bytes_q,  pkt_bytes_d;
  logic [31:0] pkt_crc_q,    pkt_crc_d;
  logic [31:0] pkt_cnt_q,    pkt_cnt_d;
  logic        err_gap_q,    err_gap_d;
  logic        err_part_q,   err_part_d;

  logic        accept;
  logic [31:0] beat_bytes;
  logic [31:0] beat_crc;

  assign accept     = tvalid & tready_q;
  assign beat_bytes = popcount(tkeep);
  assign beat_crc   = crc_beat(crc_q, tdata, tkeep);

  // Back-pressure: advance the LFSR and derive next tready from its new value.
  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    tready_d = ALWAYS_READY | (int'(lfsr_d[7:0]) < READY_PROB);
  end

  // Next-state and packet-datapath logic for the reassembly FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    acc_bytes_d = acc_bytes_q;
    crc_d       = crc_q;
    pkt_done_d  = 1'b0;
    pkt_bytes_d = pkt_bytes_q;
    pkt_crc_d   = pkt_crc_q;
    pkt_cnt_d   = pkt_cnt_q;
    err_gap_d   = err_gap_q  | (accept & ~keep_contiguous(tkeep));
    err_part_d  = err_part_q | (accept & ~tlast & (tkeep != '1));

    if (accept) begin
      if (tlast) begin
        // Close the packet and restart accumulators so a beat accepted in the
        // very next cycle opens a fresh packet.
        state_d     = IDLE;
        pkt_done_d  = 1'b1;
        pkt_bytes_d = acc_bytes_q + beat_bytes;
        pkt_crc_d   = ~beat_crc;
        pkt_cnt_d   = pkt_cnt_q + 32'd1;
        acc_bytes_d = '0;
        crc_d       = CRC_INIT;
      end else begin
        state_d     = IN_PKT;
        acc_bytes_d = acc_bytes_q + beat_bytes;
        crc_d       = beat_crc;
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_INIT;
      tready_q    <= 1'b0;
      acc_bytes_q <= '0;
      crc_q       <= CRC_INIT;
      pkt_done_q  <= 1'b0;
      pkt_bytes_q <= '0;
      pkt_crc_q   <= '0;
      pkt_cnt_q   <= '0;
      err_gap_q   <= 1'b0;
      err_part_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      tready_q    <= tready_d;
      acc_bytes_q <= acc_bytes_d;
      crc_q       <= crc_d;
      pkt_done_q  <= pkt_done_d;
      pkt_bytes_q <= pkt_bytes_d;
      pkt_crc_q   <= pkt_crc_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_gap_q   <= err_gap_d;
      err_part_q  <= err_part_d;
    end
  end

  assign tready           = tready_q;
  assign pkt_done         = pkt_done_q;
  assign pkt_bytes        = pkt_bytes_q;
  assign pkt_crc          = pkt_crc_q;
  assign pkt_cnt          = pkt_cnt_q;
  assign busy             = (state_q == IN_PKT);
  assign err_keep_gap     = err_gap_q;
  assign err_keep_partial = err_part_q;

`ifdef TB_AXI_STREAM_SINK_DISPLAY_EN
  // Simulation log: completed packets and first assertion of each error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (pkt_done_q) begin
        $display("pkt %0d: %0d bytes crc %08x", pkt_cnt_q, pkt_bytes_q, pkt_crc_q);
      end
      if (err_gap_d && !err_gap_q) begin
        $display("*** error : AXI-stream sink : tkeep gap");
      end
      if (err_part_d && !err_part_q) begin
        $display("*** error : AXI-stream sink : tkeep partial");
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_tb_axi_stream_sink.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_tb_axi_stream_sink
//   Self-checking bench for tb_axi_stream_sink. One instance is always ready
//   and is checked through a packet scoreboard; a second instance runs with
//   READY_PROB=64 to exercise back-pressure.
// -----------------------------------------------------------------------------
module tb_tb_axi_stream_sink;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // Always-ready instance
  logic        tready, tvalid = 1'b0, tlast = 1'b0;
  logic [31:0] tdata = '0;
  logic [3:0]  tkeep = '0;
  logic        pkt_done, busy, err_gap, err_part;
  logic [31:0] pkt_bytes, pkt_crc, pkt_cnt;

  // Back-pressured instance
  logic        bp_tready, bp_tvalid = 1'b0, bp_tlast = 1'b0;
  logic [31:0] bp_tdata = '0;
  logic [3:0]  bp_tkeep = '0;
  logic        bp_done, bp_busy, bp_err_gap, bp_err_part;
  logic [31:0] bp_bytes, bp_crc, bp_cnt;

  tb_axi_stream_sink #(.DWIDTH(32), .READY_PROB(256), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .tready(tready), .tvalid(tvalid), .tdata(tdata),
    .tlast(tlast), .tkeep(tkeep), .pkt_done(pkt_done), .pkt_bytes(pkt_bytes),
    .pkt_crc(pkt_crc), .pkt_cnt(pkt_cnt), .busy(busy),
    .err_keep_gap(err_gap), .err_keep_partial(err_part)
  );

  tb_axi_stream_sink #(.DWIDTH(32), .READY_PROB(64), .LFSR_SEED(16'hACE1)) dut_bp (
    .clk(clk), .rst(rst), .tready(bp_tready), .tvalid(bp_tvalid), .tdata(bp_tdata),
    .tlast(bp_tlast), .tkeep(bp_tkeep), .pkt_done(bp_done), .pkt_bytes(bp_bytes),
    .pkt_crc(bp_crc), .pkt_cnt(bp_cnt), .busy(bp_busy),
    .err_keep_gap(bp_err_gap), .err_keep_partial(bp_err_part)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08x expected %08x", tag, obs, exp);
    end
  endtask

  // Reference packet model and scoreboard
  typedef struct packed {
    logic [31:0] bytes;
    logic [31:0] crc;
  } pkt_t;

  pkt_t        exp_q[$];
  logic [31:0] m_bytes = '0;
  logic [31:0] m_crc   = 32'hFFFF_FFFF;
  logic [31:0] m_cnt   = '0;

  function automatic logic [31:0] ref_crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic model_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    pkt_t e;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) begin
        m_crc   = ref_crc_byte(m_crc, d[8*i +: 8]);
        m_bytes = m_bytes + 32'd1;
      end
    end
    if (l) begin
      e.bytes = m_bytes;
      e.crc   = ~m_crc;
      exp_q.push_back(e);
      m_bytes = '0;
      m_crc   = 32'hFFFF_FFFF;
    end
  endtask

  // Scoreboard: pop and compare on every pkt_done of the always-ready instance.
  always @(negedge clk) begin
    pkt_t e;
    if (!rst && pkt_done) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", {31'h0, pkt_done}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        m_cnt = m_cnt + 32'd1;
        check("sb_bytes", pkt_bytes, e.bytes);
        check("sb_crc",   pkt_crc,   e.crc);
        check("sb_cnt",   pkt_cnt,   m_cnt);
      end
    end
  end

  int bp_done_cnt = 0;
  always @(negedge clk) if (!rst && bp_done) bp_done_cnt++;

  // Drive one beat (called just after a negedge); returns at the negedge that
  // follows acceptance, where the pkt_done of a tlast beat is visible.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int budget;
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
    budget = 0;
    while (!tready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!tready) begin
      check("tready_timeout", {31'h0, tready}, 32'h1);
      tvalid = 1'b0;
      return;
    end
    model_beat(d, k, l);
    @(posedge clk);
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_beat_bp(input logic [31:0] d, input logic [3:0] k, input logic l);
    int budget;
    bp_tvalid = 1'b1; bp_tdata = d; bp_tkeep = k; bp_tlast = l;
    budget = 0;
    while (!bp_tready && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (!bp_tready) begin
      check("bp_tready_timeout", {31'h0, bp_tready}, 32'h1);
      bp_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bp_tvalid = 1'b0; bp_tlast = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    m_bytes = '0;
    m_crc   = 32'hFFFF_FFFF;
    m_cnt   = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] c0;
  int          ready_hi;

  initial begin
    // Reset state, observed while rst is held
    @(posedge clk);
    @(negedge clk);
    check("rst_tready",   {31'h0, tready},   32'h0);
    check("rst_done",     {31'h0, pkt_done}, 32'h0);
    check("rst_bytes",    pkt_bytes,         32'h0);
    check("rst_crc",      pkt_crc,           32'h0);
    check("rst_cnt",      pkt_cnt,           32'h0);
    check("rst_busy",     {31'h0, busy},     32'h0);
    check("rst_err_gap",  {31'h0, err_gap},  32'h0);
    check("rst_err_part", {31'h0, err_part}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: "123456789" in three beats
    send_beat(32'h34333231, 4'hF, 1'b0);
    send_beat(32'h38373635, 4'hF, 1'b0);
    check("t1_busy",     {31'h0, busy},     32'h1);
    check("t1_no_done",  {31'h0, pkt_done}, 32'h0);
    send_beat(32'h00000039, 4'h1, 1'b1);
    check("t1_done",     {31'h0, pkt_done}, 32'h1);
    check("t1_bytes",    pkt_bytes,         32'd9);
    check("t1_crc",      pkt_crc,           32'hCBF43926);
    check("t1_cnt",      pkt_cnt,           32'd1);
    check("t1_err_gap",  {31'h0, err_gap},  32'h0);
    check("t1_err_part", {31'h0, err_part}, 32'h0);
    @(negedge clk);
    check("t1_done_pulse", {31'h0, pkt_done}, 32'h0);
    check("t1_hold_crc",   pkt_crc,           32'hCBF43926);

    // 2: same packet under READY_PROB=64 back-pressure
    send_beat_bp(32'h34333231, 4'hF, 1'b0);
    send_beat_bp(32'h38373635, 4'hF, 1'b0);
    send_beat_bp(32'h00000039, 4'h1, 1'b1);
    check("t2_done",  {31'h0, bp_done}, 32'h1);
    check("t2_bytes", bp_bytes,         32'd9);
    check("t2_crc",   bp_crc,           32'hCBF43926);
    ready_hi = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (bp_tready) ready_hi++;
    end
    check("t2_ready_ge_20pct", {31'h0, (ready_hi >= 2000)}, 32'h1);
    check("t2_ready_le_30pct", {31'h0, (ready_hi <= 3000)}, 32'h1);
    check("t2_done_once",      bp_done_cnt,                 32'd1);

    // 3: empty packet
    send_beat(32'hDEADBEEF, 4'h0, 1'b1);
    check("t3_done",     {31'h0, pkt_done}, 32'h1);
    check("t3_bytes",    pkt_bytes,         32'd0);
    check("t3_crc",      pkt_crc,           32'h0);
    check("t3_cnt",      pkt_cnt,           32'd2);
    check("t3_err_gap",  {31'h0, err_gap},  32'h0);
    check("t3_err_part", {31'h0, err_part}, 32'h0);

    // 4: tkeep format errors are sticky until reset
    send_beat(32'h44332211, 4'b0101, 1'b1);
    check("t4_gap_set",     {31'h0, err_gap},  32'h1);
    check("t4_part_clear",  {31'h0, err_part}, 32'h0);
    send_beat(32'hA5A5A5A5, 4'hF, 1'b1);
    check("t4_gap_sticky",  {31'h0, err_gap},  32'h1);
    send_beat(32'h00636261, 4'b0111, 1'b0);
    check("t4_part_set",    {31'h0, err_part}, 32'h1);
    send_beat(32'h00000064, 4'h1, 1'b1);
    check("t4_part_sticky", {31'h0, err_part}, 32'h1);
    do_reset();
    check("t4_gap_rst",  {31'h0, err_gap},  32'h0);
    check("t4_part_rst", {31'h0, err_part}, 32'h0);

    // 5: reset discards a partial packet
    send_beat(32'h11111111, 4'hF, 1'b0);
    send_beat(32'h22222222, 4'hF, 1'b0);
    check("t5_busy_before", {31'h0, busy}, 32'h1);
    exp_q.delete();
    do_reset();
    check("t5_busy_after", {31'h0, busy},     32'h0);
    check("t5_no_done",    {31'h0, pkt_done}, 32'h0);
    @(negedge clk);
    send_beat(32'h00000061, 4'h1, 1'b1);
    check("t5_bytes", pkt_bytes, 32'd1);
    check("t5_crc",   pkt_crc,   32'hE8B7BE43);
    check("t5_cnt",   pkt_cnt,   32'd1);

    // 6: back-to-back single-beat packets
    @(negedge clk);
    c0 = pkt_cnt;
    send_beat(32'h000000AA, 4'h1, 1'b1);
    check("t6_done_a", {31'h0, pkt_done}, 32'h1);
    send_beat(32'h0000BBCC, 4'h3, 1'b1);
    check("t6_done_b", {31'h0, pkt_done}, 32'h1);
    check("t6_cnt",    pkt_cnt,           c0 + 32'd2);

    repeat (4) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
